snake_pixel_engine: RTL and testbench

//  Game-state and pixel-colour stage directly downstream of the VGA timing generator.

---
 rtl/snake_pixel_engine.sv | 265 ++++++++++++++++++++++++++
 tb/tb_snake_pixel_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_pixel_engine.sv
// snake_pixel_engine: snake game state plus per-pixel colour stage behind the VGA timing generator.
// The game advances once every STEP_FRAMES frames, one clock after the falling edge of vsync (inside vblank).
// Optional build macro SNAKE_WRAP_EN: walls wrap around and only a self hit ends the game.
module snake_pixel_engine #(
    parameter int          CELL_SHIFT  = 4,
    parameter int          GRID_W      = 40,
    parameter int          GRID_H      = 30,
    parameter int          MAX_LEN     = 16,
    parameter int          STEP_FRAMES = 8,
    parameter logic [11:0] COL_HEAD    = 12'h0F0,
    parameter logic [11:0] COL_BODY    = 12'h080,
    parameter logic [11:0] COL_FOOD    = 12'hF00,
    parameter logic [11:0] COL_BG      = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic        vsync,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [1:0]  dir_in,
    input  logic        dir_valid,
    input  logic        start,
    output logic [11:0] rgb,
    output logic        running,
    output logic        game_over,
    output logic [7:0]  score
);
    localparam int X_W   = $clog2(GRID_W);
    localparam int Y_W   = $clog2(GRID_H);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [X_W-1:0]   X_ZERO    = X_W'(0);
    localparam logic [X_W-1:0]   X_ONE     = X_W'(1);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(GRID_W - 1);
    localparam logic [X_W-1:0]   X_MOD     = X_W'(GRID_W);
    localparam logic [Y_W-1:0]   Y_ZERO    = Y_W'(0);
    localparam logic [Y_W-1:0]   Y_ONE     = Y_W'(1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(GRID_H - 1);
    localparam logic [Y_W-1:0]   Y_MOD     = Y_W'(GRID_H);
    localparam logic [X_W-1:0]   INIT_X    = X_W'(GRID_W / 2);
    localparam logic [Y_W-1:0]   INIT_Y    = Y_W'(GRID_H / 2);
    localparam logic [X_W-1:0]   FOOD_X0   = X_W'((GRID_W * 3) / 4);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_INIT  = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [7:0]       STEP_LAST = 8'(STEP_FRAMES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_OVER = 2'd2} state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    state_t           state_r, next_state_s;
    logic             running_r, game_over_r, running_nx_s, game_over_nx_s;
    logic             vsync_q_r, tick_r;
    logic [15:0]      lfsr_r;
    logic [7:0]       frame_cnt_r, score_r;
    logic [1:0]       dir_r, pending_r;
    logic [X_W-1:0]   seg_x_r [MAX_LEN];
    logic [Y_W-1:0]   seg_y_r [MAX_LEN];
    logic [LEN_W-1:0] len_r;
    logic [X_W-1:0]   food_x_r, food_x_raw_s, food_x_nx_s, nhx_s;
    logic [Y_W-1:0]   food_y_r, food_y_raw_s, food_y_nx_s, nhy_s;
    logic             step_s, wall_s, self_hit_s, food_hit_s, hit_s;
    logic [9:0]       cx_s, cy_s;
    logic             head_px_s, body_px_s, food_px_s;
    logic [11:0]      colour_s, rgb_r;

    assign rgb       = rgb_r;
    assign running   = running_r;
    assign game_over = game_over_r;
    assign score     = score_r;

    // Falling-edge detector on vsync producing a registered one-clock frame tick
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q_r <= 1'b1;
            tick_r    <= 1'b0;
        end else begin
            vsync_q_r <= vsync;
            tick_r    <= vsync_q_r & ~vsync;
        end
    end

    // Free-running food randomiser, only reseeded by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign step_s = (state_r == ST_RUN) && tick_r && (frame_cnt_r == STEP_LAST);

    // Candidate head cell for the pending direction, with wall detection and wrap target
    always_comb begin
        nhx_s  = seg_x_r[0];
        nhy_s  = seg_y_r[0];
        wall_s = 1'b0;
        case (pending_r)
            DIR_UP: begin
                wall_s = (seg_y_r[0] == Y_ZERO);
                nhy_s  = wall_s ? Y_LAST : seg_y_r[0] - Y_ONE;
            end
            DIR_RIGHT: begin
                wall_s = (seg_x_r[0] == X_LAST);
                nhx_s  = wall_s ? X_ZERO : seg_x_r[0] + X_ONE;
            end
            DIR_DOWN: begin
                wall_s = (seg_y_r[0] == Y_LAST);
                nhy_s  = wall_s ? Y_ZERO : seg_y_r[0] + Y_ONE;
            end
            DIR_LEFT: begin
                wall_s = (seg_x_r[0] == X_ZERO);
                nhx_s  = wall_s ? X_LAST : seg_x_r[0] - X_ONE;
            end
            default: begin
                nhx_s  = seg_x_r[0];
                nhy_s  = seg_y_r[0];
                wall_s = 1'b0;
            end
        endcase
    end

    // Food and self-collision tests; the tail only stays put when the snake grows
    always_comb begin
        food_hit_s = (nhx_s == food_x_r) && (nhy_s == food_y_r);
        self_hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            self_hit_s = self_hit_s |
                (((LEN_W'(i) < (len_r - LEN_ONE)) || (food_hit_s && (LEN_W'(i) < len_r))) &&
                 (seg_x_r[i] == nhx_s) && (seg_y_r[i] == nhy_s));
        end
    end

`ifdef SNAKE_WRAP_EN
    assign hit_s = self_hit_s;
`else
    assign hit_s = wall_s | self_hit_s;
`endif

    assign food_x_raw_s = lfsr_r[X_W-1:0];
    assign food_y_raw_s = lfsr_r[X_W+Y_W-1:X_W];
    assign food_x_nx_s  = (food_x_raw_s >= X_MOD) ? food_x_raw_s - X_MOD : food_x_raw_s;
    assign food_y_nx_s  = (food_y_raw_s >= Y_MOD) ? food_y_raw_s - Y_MOD : food_y_raw_s;

    // FSM state register with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            running_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            running_r   <= running_nx_s;
            game_over_r <= game_over_nx_s;
        end
    end

    // FSM next state: start always (re)enters RUN, a colliding step ends the game
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: if (start) next_state_s = ST_RUN; else next_state_s = ST_IDLE;
            ST_RUN: begin
                if (start)                next_state_s = ST_RUN;
                else if (step_s && hit_s) next_state_s = ST_OVER;
                else                      next_state_s = ST_RUN;
            end
            ST_OVER: if (start) next_state_s = ST_RUN; else next_state_s = ST_OVER;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the next state so they register in step with it
    always_comb begin
        running_nx_s   = 1'b0;
        game_over_nx_s = 1'b0;
        case (next_state_s)
            ST_RUN:  running_nx_s   = 1'b1;
            ST_OVER: game_over_nx_s = 1'b1;
            default: begin
                running_nx_s   = 1'b0;
                game_over_nx_s = 1'b0;
            end
        endcase
    end

    // Game data: init on reset/start, frame counting, direction latch and the step itself
    always_ff @(posedge clk) begin
        if (reset || start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= (LEN_W'(i) < LEN_INIT) ? INIT_X - X_W'(i) : X_ZERO;
                seg_y_r[i] <= (LEN_W'(i) < LEN_INIT) ? INIT_Y : Y_ZERO;
            end
            len_r       <= LEN_INIT;
            dir_r       <= DIR_RIGHT;
            pending_r   <= DIR_RIGHT;
            food_x_r    <= FOOD_X0;
            food_y_r    <= INIT_Y;
            score_r     <= 8'd0;
            frame_cnt_r <= 8'd0;
        end else begin
            if ((state_r == ST_RUN) && tick_r) begin
                frame_cnt_r <= (frame_cnt_r == STEP_LAST) ? 8'd0 : frame_cnt_r + 8'd1;
            end
            // a request to turn straight back into the neck is dropped
            if (dir_valid && (dir_in != (dir_r ^ 2'b10))) begin
                pending_r <= dir_in;
            end
            if (step_s) begin
                dir_r <= pending_r;
                if (!hit_s) begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x_r[i] <= seg_x_r[i-1];
                        seg_y_r[i] <= seg_y_r[i-1];
                    end
                    seg_x_r[0] <= nhx_s;
                    seg_y_r[0] <= nhy_s;
                    if (food_hit_s) begin
                        len_r    <= (len_r == LEN_MAX) ? LEN_MAX : len_r + LEN_ONE;
                        score_r  <= (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
                        food_x_r <= food_x_nx_s;
                        food_y_r <= food_y_nx_s;
                    end
                end
            end
        end
    end

    // Cell lookup for the current pixel with head > body > food > background priority
    always_comb begin
        cx_s      = pixel_x >> CELL_SHIFT;
        cy_s      = pixel_y >> CELL_SHIFT;
        head_px_s = (cx_s == 10'(seg_x_r[0])) && (cy_s == 10'(seg_y_r[0]));
        food_px_s = (cx_s == 10'(food_x_r)) && (cy_s == 10'(food_y_r));
        body_px_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            body_px_s = body_px_s | ((LEN_W'(i) < len_r) &&
                        (cx_s == 10'(seg_x_r[i])) && (cy_s == 10'(seg_y_r[i])));
        end
        if (head_px_s)      colour_s = (state_r == ST_OVER) ? 12'hFFF : COL_HEAD;
        else if (body_px_s) colour_s = COL_BODY;
        else if (food_px_s) colour_s = COL_FOOD;
        else                colour_s = COL_BG;
    end

    // Registered pixel output, blanked outside active video
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= video_on ? colour_s : 12'h000;
        end
    end
endmodule

// File: tb/tb_snake_pixel_engine.sv
// Self-checking bench for snake_pixel_engine: directed scenarios plus random steering,
// compared against a queue-based model of the game rules. Follows SNAKE_WRAP_EN if defined.
module tb_snake_pixel_engine;
    localparam int GW = 40, GH = 30, MAXL = 16, STEPF = 8;
    localparam logic [11:0] C_HEAD = 12'h0F0, C_BODY = 12'h080, C_FOOD = 12'hF00,
                            C_BG = 12'h000, C_DEAD = 12'hFFF;
    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;

    logic clk = 1'b0, reset = 1'b1, video_on = 1'b0, vsync = 1'b1;
    logic [9:0] pixel_x = 10'd0, pixel_y = 10'd0;
    logic [1:0] dir_in = 2'b00;
    logic dir_valid = 1'b0, start = 1'b0;
    logic [11:0] rgb;
    logic running, game_over;
    logic [7:0] score;

    int n_cmp = 0, n_err = 0;

    // reference model of the game
    int bx[$], by[$];
    int m_len, m_fx, m_fy, m_score, m_fcnt, m_state;
    logic [1:0] m_dir, m_pend;
    logic [15:0] m_lfsr;

    snake_pixel_engine dut (
        .clk(clk), .reset(reset), .video_on(video_on), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .dir_in(dir_in), .dir_valid(dir_valid),
        .start(start), .rgb(rgb), .running(running), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        int b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return 16'((l >> 1) | (b << 15));
    endfunction

    // model copy of the free-running randomiser
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= lfsr_adv(m_lfsr);
    end

    function automatic int ddx(input logic [1:0] d);
        return (d == 2'b01) ? 1 : ((d == 2'b11) ? -1 : 0);
    endfunction
    function automatic int ddy(input logic [1:0] d);
        return (d == 2'b10) ? 1 : ((d == 2'b00) ? -1 : 0);
    endfunction

    function automatic logic [11:0] model_colour(input int cx, input int cy);
        if (bx[0] == cx && by[0] == cy) return (m_state == M_OVER) ? C_DEAD : C_HEAD;
        for (int i = 1; i < m_len; i++) if (bx[i] == cx && by[i] == cy) return C_BODY;
        if (m_fx == cx && m_fy == cy) return C_FOOD;
        return C_BG;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_init(input int st);
        bx = '{20, 19, 18};
        by = '{15, 15, 15};
        m_len = 3; m_dir = 2'b01; m_pend = 2'b01;
        m_fx = 30; m_fy = 15; m_score = 0; m_fcnt = 0; m_state = st;
    endtask

    task automatic model_step(input logic [15:0] lf);
        int nx, ny, lim;
        bit wall, self_h, fh;
        m_dir = m_pend;
        nx = bx[0] + ddx(m_dir);
        ny = by[0] + ddy(m_dir);
        wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        wall = 1'b0;
`endif
        fh = (nx == m_fx) && (ny == m_fy);
        lim = fh ? m_len : m_len - 1;
        self_h = 1'b0;
        for (int i = 0; i < lim; i++) if (bx[i] == nx && by[i] == ny) self_h = 1'b1;
        if (wall || self_h) begin
            m_state = M_OVER;
            return;
        end
        bx.push_front(nx);
        by.push_front(ny);
        if (fh) begin
            if (m_len < MAXL) m_len++;
            if (m_score < 255) m_score++;
            m_fx = int'(lf & 16'h003F) % GW;
            m_fy = int'((lf >> 6) & 16'h001F) % GH;
        end
        while (bx.size() > m_len) begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
    endtask

    // one vsync low pulse; the model steps on every STEP_FRAMES-th tick while running
    task automatic frame();
        logic [15:0] lf0;
        @(negedge clk); vsync = 1'b0; lf0 = m_lfsr;
        @(negedge clk); @(negedge clk); vsync = 1'b1;
        @(negedge clk); @(negedge clk);
        if (m_state == M_RUN) begin
            if (m_fcnt == STEPF - 1) begin
                m_fcnt = 0;
                model_step(lfsr_adv(lf0));
            end else begin
                m_fcnt++;
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        model_init(M_RUN);
    endtask

    task automatic press(input logic [1:0] d);
        @(negedge clk); dir_in = d; dir_valid = 1'b1;
        @(negedge clk); dir_valid = 1'b0;
        if (!(ddx(d) == -ddx(m_dir) && ddy(d) == -ddy(m_dir))) m_pend = d;
    endtask

    task automatic check_cell(input string tag, input int cx, input int cy, input logic [11:0] exp_c);
        @(negedge clk);
        pixel_x = 10'(cx * 16 + 8); pixel_y = 10'(cy * 16 + 8); video_on = 1'b1;
        @(negedge clk);
        chk(tag, 32'(rgb), 32'(exp_c));
    endtask

    task automatic check_model(input string tag);
        int rx, ry;
        chk({tag, ":running"}, 32'(running), (m_state == M_RUN) ? 1 : 0);
        chk({tag, ":game_over"}, 32'(game_over), (m_state == M_OVER) ? 1 : 0);
        chk({tag, ":score"}, 32'(score), m_score);
        for (int i = 0; i < bx.size(); i++) check_cell({tag, ":seg"}, bx[i], by[i], model_colour(bx[i], by[i]));
        check_cell({tag, ":food"}, m_fx, m_fy, model_colour(m_fx, m_fy));
        for (int k = 0; k < 3; k++) begin
            rx = $urandom_range(GW - 1, 0);
            ry = $urandom_range(GH - 1, 0);
            check_cell({tag, ":rand_cell"}, rx, ry, model_colour(rx, ry));
        end
    endtask

    initial begin
        // 1: reset clears outputs even with an active head pixel presented
        video_on = 1'b1; pixel_x = 10'd328; pixel_y = 10'd248;
        repeat (3) @(negedge clk);
        chk("reset:rgb", 32'(rgb), 32'h000);
        chk("reset:running", 32'(running), 0);
        chk("reset:game_over", 32'(game_over), 0);
        chk("reset:score", 32'(score), 0);
        reset = 1'b0;
        model_init(M_IDLE);
        @(negedge clk);
        chk("idle:head_pixel", 32'(rgb), 32'(C_HEAD));
        check_model("idle");

        // 2: one step right, blanking forces black
        do_start();
        repeat (STEPF) frame();
        check_cell("t2:head", 21, 15, C_HEAD);
        check_cell("t2:body1", 20, 15, C_BODY);
        check_cell("t2:body2", 19, 15, C_BODY);
        check_cell("t2:old_tail", 18, 15, C_BG);
        @(negedge clk); video_on = 1'b0; pixel_x = 10'd344; pixel_y = 10'd248;
        @(negedge clk); chk("t2:blank_head", 32'(rgb), 32'h000);
        check_model("t2");

        // 3: ten steps right eats the initial food
        do_start();
        repeat (10 * STEPF) frame();
        chk("t3:score", 32'(score), 1);
        check_cell("t3:head", 30, 15, C_HEAD);
        check_cell("t3:len4_tail", 27, 15, C_BODY);
        chk("t3:food_in_range", (m_fx < GW && m_fy < GH) ? 1 : 0, 1);
        check_model("t3");

        // 4: reversal ignored, then turn up
        press(2'b11);
        press(2'b00);
        repeat (STEPF) frame();
        check_cell("t4:head_up", 30, 14, C_HEAD);
        check_model("t4");

        // 5: run into the right-hand wall
        do_start();
        repeat (20 * STEPF) frame();
`ifdef SNAKE_WRAP_EN
        check_cell("t5:wrap_head", 0, 15, C_HEAD);
        chk("t5:running", 32'(running), 1);
`else
        check_cell("t5:frozen_head", 39, 15, C_DEAD);
        chk("t5:game_over", 32'(game_over), 1);
`endif
        check_model("t5");

        // 6a: reset asserted across the step tick
        do_start();
        repeat (STEPF - 1) frame();
        @(negedge clk); vsync = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b1; reset = 1'b0;
        repeat (2) @(negedge clk);
        model_init(M_IDLE);
        check_cell("t6a:head", 20, 15, C_HEAD);
        check_model("t6a");

        // 6b: start held across the step tick wins, counting restarts
        do_start();
        repeat (STEPF - 1) frame();
        @(negedge clk); start = 1'b1;
        @(negedge clk); vsync = 1'b0;
        @(negedge clk); @(negedge clk); start = 1'b0;
        @(negedge clk); vsync = 1'b1;
        repeat (2) @(negedge clk);
        model_init(M_RUN);
        check_cell("t6b:no_step", 20, 15, C_HEAD);
        check_model("t6b");
        repeat (STEPF) frame();
        check_cell("t6b:one_step", 21, 15, C_HEAD);
        check_model("t6b_after");

        // random steering against the model
        for (int g = 0; g < 3; g++) begin
            do_start();
            for (int s = 0; s < 15; s++) begin
                if (m_state != M_RUN) break;
                if ($urandom_range(1, 0) == 1) press(2'($urandom_range(3, 0)));
                repeat (STEPF) frame();
                check_model("rand");
            end
            repeat (STEPF) frame();
            check_model("rand_end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
